// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Pipeline hazard/stall scheduler for the 5-stage MIPS core. It works
//   alongside the forwarding unit and covers the cases forwarding cannot:
//     - load-use hazards (load in EX feeding the instruction in ID);
//     - branch/jr operand hazards (operands are resolved in ID, so a value
//       still being produced in EX, or a load in MEM, must be waited for);
//     - I/D cache-miss freezes from the L1/L2 hierarchy;
//     - structural hazards on the multi-cycle mult/div unit (MDU), tracked
//       by a small FSM plus a down-counter.
//
// Parameters:
//   MULT_LAT  cycles from mult issue (EX) to HI/LO valid, 2..255
//   DIV_LAT   cycles from div issue (EX) to HI/LO valid, 2..255
//   CNT_W     width of the performance counters
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ICacheStall, DCacheStall  cache-miss freeze requests
//   RegWrite_IE, MemtoReg_IE  EX-stage writes a register / is a load
//   MemtoReg_EM               MEM-stage is a load
//   RegisterRd_IE/_EM         EX/MEM destination registers
//   RegisterRs_FD/Rt_FD       ID-stage source registers
//   Branch_FD                 ID holds beq/bne/jr
//   MduStart_FD, MduRead_FD   ID holds mult/div, mfhi/mflo
//   MduStart_IE, MduIsDiv_IE  EX issues an MDU op this cycle / it is a divide
//   StallF..StallW, FlushE    pipeline stall and bubble controls
//   MduBusy, MduDone          MDU in flight / HI-LO valid next cycle
//
// Configuration:
//   HAZARD_PERF_CNT_EN  when defined, adds StallCycles and FlushCycles
//                       (CNT_W bits, saturating, cleared on rst).
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ICacheStall,
    input  logic       DCacheStall,
    input  logic       RegWrite_IE,
    input  logic       MemtoReg_IE,
    input  logic       MemtoReg_EM,
    input  logic [4:0] RegisterRd_IE,
    input  logic [4:0] RegisterRd_EM,
    input  logic [4:0] RegisterRs_FD,
    input  logic [4:0] RegisterRt_FD,
    input  logic       Branch_FD,
    input  logic       MduStart_FD,
    input  logic       MduRead_FD,
    input  logic       MduStart_IE,
    input  logic       MduIsDiv_IE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       StallE,
    output logic       StallM,
    output logic       StallW,
    output logic       MduBusy,
    output logic       MduDone
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCycles
`endif
);

    // Elaboration-time guards on the parameter ranges.
    if (MULT_LAT < 2 || MULT_LAT > 255) begin : g_bad_mult_lat
        $error("hazard_ctrl: MULT_LAT must be in 2..255");
    end
    if (DIV_LAT < 2 || DIV_LAT > 255) begin : g_bad_div_lat
        $error("hazard_ctrl: DIV_LAT must be in 2..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl: CNT_W must be at least 1");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The counter is loaded with LAT-2: one cycle is the issue cycle itself
    // and one is the DONE cycle, so BUSY lasts LAT-1 cycles.
    localparam logic [7:0] MULT_LOAD = 8'(MULT_LAT - 2);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_LAT - 2);

    logic [1:0] state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    logic match_ie, match_em;
    logic lu, br, md, frz, hz;
    logic start_ok;

    // ------------------------------------------------------------------
    // Hazard detection. $zero is never a real dependency.
    // ------------------------------------------------------------------
    assign match_ie = (RegisterRd_IE != 5'd0) &&
                      ((RegisterRd_IE == RegisterRs_FD) || (RegisterRd_IE == RegisterRt_FD));
    assign match_em = (RegisterRd_EM != 5'd0) &&
                      ((RegisterRd_EM == RegisterRs_FD) || (RegisterRd_EM == RegisterRt_FD));

    assign lu  = MemtoReg_IE && match_ie;
    // A load in MEM cannot be forwarded into ID in time; an ALU result
    // in MEM can, so only MemtoReg_EM matters for the MEM term.
    assign br  = Branch_FD && ((RegWrite_IE && match_ie) || (MemtoReg_EM && match_em));
    // Any MDU instruction in ID waits while an operation is outstanding.
    assign md  = (MduStart_FD || MduRead_FD) && (state != S_IDLE);
    assign frz = ICacheStall || DCacheStall;
    assign hz  = lu || br || md;

    // A frozen pipeline does not actually advance the EX instruction,
    // so an issue seen during a freeze is not taken.
    assign start_ok = MduStart_IE && !frz;

    // ------------------------------------------------------------------
    // Stall / flush outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        StallF = 1'b0;
        StallD = 1'b0;
        FlushE = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        if (rst) begin
            // All controls held inactive during reset.
        end else if (frz) begin
            // Whole pipe freezes; no bubble, the EX instruction is kept.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else if (hz) begin
            // Hold the front end and push a bubble into EX.
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // MDU sequencer. The MDU runs independently of pipeline freezes, so
    // the countdown continues regardless of frz.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = MduIsDiv_IE ? DIV_LOAD : MULT_LOAD;
                end
            end
            S_BUSY: begin
                // A start here is a protocol violation (md stalls ID) and
                // is simply ignored.
                if (cnt == 8'd0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_DONE: begin
                if (start_ok) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = MduIsDiv_IE ? DIV_LOAD : MULT_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Decoded straight from the state register, so both are glitch-free
    // registered signals.
    assign MduBusy = (state == S_BUSY);
    assign MduDone = (state == S_DONE);

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCycles <= '0;
            FlushCycles <= '0;
        end else begin
            if (StallF && (StallCycles != '1)) begin
                StallCycles <= StallCycles + 1'b1;
            end
            if (FlushE && (FlushCycles != '1)) begin
                FlushCycles <= FlushCycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl (MULT_LAT=4, DIV_LAT=32, CNT_W=4).
// Each cycle the bench drives an input record shortly after the rising edge,
// pushes the expected output word to a scoreboard queue, and on the falling
// edge pops it and compares against the DUT. Output word layout:
//   {StallF, StallD, FlushE, StallE, StallM, StallW, MduBusy, MduDone}
// A mask selects which bits are compared for a given cycle.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;
    localparam int CNT_W    = 4;

    // Expected-output building blocks.
    localparam logic [7:0] NONE = 8'b000000_00;
    localparam logic [7:0] HZ   = 8'b111000_00;  // StallF, StallD, FlushE
    localparam logic [7:0] FZ   = 8'b110111_00;  // all five stalls, no flush
    localparam logic [7:0] BSY  = 8'b000000_10;
    localparam logic [7:0] DN   = 8'b000000_01;
    localparam logic [7:0] ALL  = 8'hFF;
    localparam logic [7:0] MDUM = 8'b000000_11;  // compare MDU bits only

    typedef struct {
        logic       rst;
        logic       icache;
        logic       dcache;
        logic       regwrite_ie;
        logic       memtoreg_ie;
        logic       memtoreg_em;
        logic [4:0] rd_ie;
        logic [4:0] rd_em;
        logic [4:0] rs_fd;
        logic [4:0] rt_fd;
        logic       branch_fd;
        logic       mdustart_fd;
        logic       mduread_fd;
        logic       mdustart_ie;
        logic       mduisdiv_ie;
    } vec_t;

    typedef struct {
        string      name;
        vec_t       in;
        logic [7:0] out;
    } case_t;

    typedef struct {
        string      name;
        logic [7:0] val;
        logic [7:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ICacheStall = 1'b0, DCacheStall = 1'b0;
    logic       RegWrite_IE = 1'b0, MemtoReg_IE = 1'b0, MemtoReg_EM = 1'b0;
    logic [4:0] RegisterRd_IE = '0, RegisterRd_EM = '0, RegisterRs_FD = '0, RegisterRt_FD = '0;
    logic       Branch_FD = 1'b0, MduStart_FD = 1'b0, MduRead_FD = 1'b0;
    logic       MduStart_IE = 1'b0, MduIsDiv_IE = 1'b0;
    logic       StallF, StallD, FlushE, StallE, StallM, StallW, MduBusy, MduDone;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] StallCycles, FlushCycles;
`endif

    logic [7:0] outs;
    assign outs = {StallF, StallD, FlushE, StallE, StallM, StallW, MduBusy, MduDone};

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    hazard_ctrl #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ICacheStall  (ICacheStall),
        .DCacheStall  (DCacheStall),
        .RegWrite_IE  (RegWrite_IE),
        .MemtoReg_IE  (MemtoReg_IE),
        .MemtoReg_EM  (MemtoReg_EM),
        .RegisterRd_IE(RegisterRd_IE),
        .RegisterRd_EM(RegisterRd_EM),
        .RegisterRs_FD(RegisterRs_FD),
        .RegisterRt_FD(RegisterRt_FD),
        .Branch_FD    (Branch_FD),
        .MduStart_FD  (MduStart_FD),
        .MduRead_FD   (MduRead_FD),
        .MduStart_IE  (MduStart_IE),
        .MduIsDiv_IE  (MduIsDiv_IE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushE       (FlushE),
        .StallE       (StallE),
        .StallM       (StallM),
        .StallW       (StallW),
        .MduBusy      (MduBusy),
        .MduDone      (MduDone)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles  (StallCycles),
        .FlushCycles  (FlushCycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    function automatic vec_t nop();
        vec_t v;
        v.rst = 1'b0;          v.icache = 1'b0;      v.dcache = 1'b0;
        v.regwrite_ie = 1'b0;  v.memtoreg_ie = 1'b0; v.memtoreg_em = 1'b0;
        v.rd_ie = 5'd0;        v.rd_em = 5'd0;
        v.rs_fd = 5'd0;        v.rt_fd = 5'd0;
        v.branch_fd = 1'b0;    v.mdustart_fd = 1'b0; v.mduread_fd = 1'b0;
        v.mdustart_ie = 1'b0;  v.mduisdiv_ie = 1'b0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst           = v.rst;
        ICacheStall   = v.icache;
        DCacheStall   = v.dcache;
        RegWrite_IE   = v.regwrite_ie;
        MemtoReg_IE   = v.memtoreg_ie;
        MemtoReg_EM   = v.memtoreg_em;
        RegisterRd_IE = v.rd_ie;
        RegisterRd_EM = v.rd_em;
        RegisterRs_FD = v.rs_fd;
        RegisterRt_FD = v.rt_fd;
        Branch_FD     = v.branch_fd;
        MduStart_FD   = v.mdustart_fd;
        MduRead_FD    = v.mduread_fd;
        MduStart_IE   = v.mdustart_ie;
        MduIsDiv_IE   = v.mduisdiv_ie;
    endtask

    // One clock cycle: drive, push expectation, sample on falling edge.
    task automatic step(input vec_t v, input string name, input logic [7:0] exp, input logic [7:0] mask);
        exp_t e;
        @(posedge clk);
        #1;
        apply(v);
        sb.push_back('{name, exp, mask});
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check(e.name, 32'(outs & e.mask), 32'(e.val & e.mask));
        end
    endtask

    // Load-use hazard on rs with lw $3 in EX.
    function automatic vec_t lu_vec();
        vec_t v = nop();
        v.memtoreg_ie = 1'b1;
        v.rd_ie = 5'd3;
        v.rs_fd = 5'd3;
        return v;
    endfunction

    initial begin
        case_t tbl[$];
        case_t tc;
        vec_t  v;

        // ---------------- combinational vector table (MDU idle) ----------
        tc.in = nop(); tc.name = "idle_all_zero"; tc.out = NONE; tbl.push_back(tc);
        tc.in = lu_vec(); tc.name = "lu_rs"; tc.out = HZ; tbl.push_back(tc);
        tc.in = nop(); tc.name = "lu_one_cycle_only"; tc.out = NONE; tbl.push_back(tc);
        tc.in = nop(); tc.in.memtoreg_ie = 1; tc.in.rd_ie = 7; tc.in.rt_fd = 7; tc.in.rs_fd = 2;
        tc.name = "lu_rt"; tc.out = HZ; tbl.push_back(tc);
        tc.in = nop(); tc.in.memtoreg_ie = 1; tc.in.rd_ie = 3; tc.in.rs_fd = 4; tc.in.rt_fd = 5;
        tc.name = "lu_no_match"; tc.out = NONE; tbl.push_back(tc);
        tc.in = nop(); tc.in.memtoreg_ie = 1; tc.in.rd_ie = 0; tc.in.rs_fd = 0;
        tc.name = "lu_zero_reg"; tc.out = NONE; tbl.push_back(tc);
        tc.in = nop(); tc.in.branch_fd = 1; tc.in.regwrite_ie = 1; tc.in.rd_ie = 5; tc.in.rt_fd = 5;
        tc.name = "br_ex"; tc.out = HZ; tbl.push_back(tc);
        tc.in = nop(); tc.in.branch_fd = 1; tc.in.memtoreg_em = 1; tc.in.rd_em = 5; tc.in.rt_fd = 5;
        tc.name = "br_mem_load"; tc.out = HZ; tbl.push_back(tc);
        tc.in = nop(); tc.in.regwrite_ie = 1; tc.in.rd_ie = 5; tc.in.rt_fd = 5;
        tc.name = "alu_dep_no_branch"; tc.out = NONE; tbl.push_back(tc);
        tc.in = nop(); tc.in.branch_fd = 1; tc.in.rd_em = 5; tc.in.rs_fd = 5;
        tc.name = "br_mem_alu_fwd"; tc.out = NONE; tbl.push_back(tc);
        tc.in = nop(); tc.in.branch_fd = 1; tc.in.memtoreg_em = 1; tc.in.rd_em = 0; tc.in.rs_fd = 0;
        tc.name = "br_mem_zero_reg"; tc.out = NONE; tbl.push_back(tc);
        tc.in = nop(); tc.in.icache = 1; tc.name = "icache_freeze"; tc.out = FZ; tbl.push_back(tc);
        tc.in = lu_vec(); tc.in.dcache = 1; tc.name = "dcache_over_lu"; tc.out = FZ; tbl.push_back(tc);
        tc.in = nop(); tc.in.mduread_fd = 1; tc.in.mdustart_fd = 1;
        tc.name = "mdu_read_idle"; tc.out = NONE; tbl.push_back(tc);

        // ---------------- reset ----------------
        v = lu_vec(); v.rst = 1;
        step(v, "rst_outputs_forced_0", NONE, ALL);
        v.mdustart_ie = 1;
        step(v, "rst_start_ignored", NONE, ALL);
        step(nop(), "after_rst_idle", NONE, ALL);

        foreach (tbl[i]) begin
            step(tbl[i].in, tbl[i].name, tbl[i].out, ALL);
        end

        // ---------------- mult latency with mfhi waiting ----------------
        v = nop(); v.mdustart_ie = 1;
        step(v, "mult_issue", NONE, ALL);
        for (int i = 1; i < MULT_LAT; i++) begin
            v = nop(); v.mduread_fd = 1;
            step(v, "mult_busy", HZ | BSY, ALL);
        end
        v = nop(); v.mduread_fd = 1;
        step(v, "mult_done", DN, MDUM);
        step(v, "mult_read_released", NONE, ALL);

        // ---------------- div latency with mflo waiting ----------------
        v = nop(); v.mdustart_ie = 1; v.mduisdiv_ie = 1;
        step(v, "div_issue", NONE, ALL);
        for (int i = 1; i < DIV_LAT; i++) begin
            v = nop(); v.mduread_fd = 1;
            step(v, "div_busy", HZ | BSY, ALL);
        end
        v = nop(); v.mduread_fd = 1;
        step(v, "div_done", DN, MDUM);
        step(v, "div_read_released", NONE, ALL);

        // ---------------- freeze during div ----------------
        v = nop(); v.mdustart_ie = 1; v.mduisdiv_ie = 1;
        step(v, "frz_div_issue", NONE, ALL);
        for (int i = 1; i < DIV_LAT; i++) begin
            if (i >= 5 && i <= 9) begin
                v = lu_vec(); v.dcache = 1; v.mdustart_ie = 1;
                step(v, "frz_div_busy_frozen", FZ | BSY, ALL);
            end else begin
                step(nop(), "frz_div_busy", BSY, ALL);
            end
        end
        v = nop(); v.dcache = 1; v.mdustart_ie = 1;
        step(v, "frz_div_done_on_time", FZ | DN, ALL);
        step(nop(), "frz_done_start_dropped", NONE, ALL);
        v = nop(); v.icache = 1; v.mdustart_ie = 1;
        step(v, "frz_idle_start", FZ, ALL);
        step(nop(), "frz_idle_start_dropped", NONE, ALL);

        // ---------------- back-to-back issue from DONE ----------------
        v = nop(); v.mdustart_ie = 1;
        step(v, "b2b_issue", NONE, ALL);
        for (int i = 1; i < MULT_LAT; i++) step(nop(), "b2b_busy1", BSY, ALL);
        step(v, "b2b_done_restart", DN, ALL);
        for (int i = 1; i < MULT_LAT; i++) step(nop(), "b2b_busy2", BSY, ALL);
        step(nop(), "b2b_done2", DN, ALL);
        step(nop(), "b2b_idle", NONE, ALL);

        // ---------------- reset mid-operation ----------------
        v = nop(); v.mdustart_ie = 1;
        step(v, "rstop_issue", NONE, ALL);
        v = lu_vec(); v.rst = 1;
        step(v, "rstop_rst_in_busy", BSY, ALL);
        step(nop(), "rstop_idle_after", NONE, ALL);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_cleared", 32'(StallCycles), 32'd0);
        check("perf_flush_cleared", 32'(FlushCycles), 32'd0);
`endif
        for (int i = 0; i < MULT_LAT + 1; i++) step(nop(), "rstop_no_done", NONE, ALL);

`ifdef HAZARD_PERF_CNT_EN
        // ---------------- performance counters ----------------
        for (int i = 0; i < 3; i++) step(lu_vec(), "perf_lu", HZ, ALL);
        step(nop(), "perf_gap", NONE, ALL);
        check("perf_stall_3", 32'(StallCycles), 32'd3);
        check("perf_flush_3", 32'(FlushCycles), 32'd3);
        v = nop(); v.icache = 1;
        for (int i = 0; i < 2; i++) step(v, "perf_frz", FZ, ALL);
        step(nop(), "perf_gap2", NONE, ALL);
        check("perf_stall_5", 32'(StallCycles), 32'd5);
        check("perf_flush_still_3", 32'(FlushCycles), 32'd3);
        for (int i = 0; i < 20; i++) step(lu_vec(), "perf_lu_sat", HZ, ALL);
        step(nop(), "perf_gap3", NONE, ALL);
        check("perf_stall_sat", 32'(StallCycles), 32'd15);
        check("perf_flush_sat", 32'(FlushCycles), 32'd15);
`endif

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
